id_ex_stage: RTL

ID/EX pipeline register and operand-selection stage that feeds the Alu in the RV32IC core. It captures decoded operands, immediate, PC and the 4-bit ALU select at the end of decode. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, then presents final ALU operands a/b and select to the Alu. It supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// Captures decoded fields, then forwards and muxes final ALU operands a/b for the Alu.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1_addr,
    input  logic [REGW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic [3:0]      id_alu_sel,
    input  logic [REGW-1:0] id_rd_addr,
    input  logic            id_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_sel,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b
);

    logic            valid_q,     valid_d;
    logic [REGW-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REGW-1:0] rs2_addr_q,  rs2_addr_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic            use_imm_q,   use_imm_d;
    logic            use_pc_q,    use_pc_d;
    logic [3:0]      alu_sel_q,   alu_sel_d;
    logic [REGW-1:0] rd_q,        rd_d;
    logic            reg_write_q, reg_write_d;

    // Flush wins over stall; a bubble clears every field so nothing stale can forward.
    always_comb begin
        valid_d     = valid_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        use_imm_d   = use_imm_q;
        use_pc_d    = use_pc_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            pc_d        = '0;
            use_imm_d   = 1'b0;
            use_pc_d    = 1'b0;
            alu_sel_d   = 4'b0000;
            rd_d        = '0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            pc_d        = id_pc;
            use_imm_d   = id_use_imm;
            use_pc_d    = id_use_pc;
            alu_sel_d   = id_alu_sel;
            rd_d        = id_rd_addr;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            alu_sel_q   <= 4'b0000;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            use_imm_q   <= use_imm_d;
            use_pc_q    <= use_pc_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    // Youngest producer (EX/MEM) wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_src(input logic [REGW-1:0] rs);
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
            return 2'b10;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        ex_fwd_a = fwd_src(rs1_addr_q);
        ex_fwd_b = fwd_src(rs2_addr_q);
        case (ex_fwd_a)
            2'b10:   fwd_rs1 = exmem_result;
            2'b01:   fwd_rs1 = memwb_result;
            default: fwd_rs1 = rs1_data_q;
        endcase
        case (ex_fwd_b)
            2'b10:   fwd_rs2 = exmem_result;
            2'b01:   fwd_rs2 = memwb_result;
            default: fwd_rs2 = rs2_data_q;
        endcase
    end

    assign ex_a          = use_pc_q  ? pc_q  : fwd_rs1;
    assign ex_b          = use_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign ex_sel        = alu_sel_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;

endmodule
